// File: rtl/unipolar_rz_pkg.sv
// Shared definitions for the unipolar RZ line encoder/receiver pair.
// Time-to-cycle conversion lives here so both ends round pulse widths identically.
package unipolar_rz_pkg;

  typedef enum logic [1:0] {
    WAIT_GAP,
    IDLE,
    HIGH,
    LOW
  } rz_state_e;

  function automatic int time_to_cycles(input real clock_rate, input real seconds);
    return int'(clock_rate * seconds);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input, followed by a registered
// edge detector; level, rise and fall are mutually aligned.
module sync_edge_detect #(
  parameter int unsigned STAGES = 2,
  parameter bit          INIT   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              level_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= {STAGES{INIT}};
      level_q <= INIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], async_in};
      level_q <= sync_q[STAGES-1];
      rise_q  <= sync_q[STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[STAGES-1] & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/unipolar_rz_receiver.sv
// Unipolar return-to-zero receiver: times each high pulse on the line and
// assembles LSB-first words; a long low gap closes the frame.
module unipolar_rz_receiver
  import unipolar_rz_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 24,
  parameter int unsigned CLOCK_RATE         = 50_000_000,
  parameter real         MIN_HIGH_TIME      = 0.15e-6,
  parameter real         BIT_THRESHOLD_TIME = 0.6e-6,
  parameter real         MAX_HIGH_TIME      = 2.0e-6,
  parameter real         RESET_TIME         = 50e-6,
  parameter bit          INVERT             = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  line,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  frame_end,
  output logic                  error
);

  localparam int MIN_HIGH_CYCLES      = time_to_cycles(real'(CLOCK_RATE), MIN_HIGH_TIME);
  localparam int BIT_THRESHOLD_CYCLES = time_to_cycles(real'(CLOCK_RATE), BIT_THRESHOLD_TIME);
  localparam int MAX_HIGH_CYCLES      = time_to_cycles(real'(CLOCK_RATE), MAX_HIGH_TIME);
  localparam int RESET_CYCLES         = time_to_cycles(real'(CLOCK_RATE), RESET_TIME);
  localparam int COUNT_LIMIT = (RESET_CYCLES > MAX_HIGH_CYCLES) ? RESET_CYCLES : MAX_HIGH_CYCLES;
  localparam int CNT_W       = $clog2(COUNT_LIMIT + 1);
  localparam int BC_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_HIGH_CYCLES);
  localparam logic [CNT_W-1:0] THR_C   = CNT_W'(BIT_THRESHOLD_CYCLES);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_HIGH_CYCLES);
  localparam logic [CNT_W-1:0] RESET_C = CNT_W'(RESET_CYCLES);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_WIDTH - 1);

  logic sync_level, raw_rise, raw_fall;
  logic level, rise, fall;

  sync_edge_detect #(
    .STAGES(2),
    .INIT  (INVERT)
  ) u_sync_edge_detect (
    .clock   (clock),
    .reset   (reset),
    .async_in(line),
    .level   (sync_level),
    .rise    (raw_rise),
    .fall    (raw_fall)
  );

  // Inverting after the edge register just swaps which edge is the "rise".
  assign level = sync_level ^ INVERT;
  assign rise  = INVERT ? raw_fall : raw_rise;
  assign fall  = INVERT ? raw_rise : raw_fall;

  rz_state_e             state_q;
  logic [CNT_W-1:0]      counter_q;
  logic [CNT_W-1:0]      counter_inc;
  logic [BC_W-1:0]       bit_count_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] word_next;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, frame_end_q, error_q;
  logic                  bit_val;

  always_comb begin
    counter_inc            = (counter_q == '1) ? counter_q : counter_q + CNT_W'(1);
    bit_val                = (counter_q > THR_C);
    word_next              = shift_q;
    word_next[bit_count_q] = bit_val;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= WAIT_GAP;
      counter_q   <= '0;
      bit_count_q <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_end_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      frame_end_q <= 1'b0;
      error_q     <= 1'b0;
      case (state_q)
        WAIT_GAP: begin
          if (level) begin
            counter_q <= '0;
          end else if (counter_inc == RESET_C) begin
            counter_q <= '0;
            state_q   <= IDLE;
          end else begin
            counter_q <= counter_inc;
          end
        end
        IDLE: begin
          if (rise) begin
            counter_q <= '0;
            state_q   <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            counter_q <= '0;
            if (counter_q < MIN_C) begin
              error_q     <= 1'b1;
              bit_count_q <= '0;
              state_q     <= WAIT_GAP;
            end else begin
              shift_q <= word_next;
              state_q <= LOW;
              if (bit_count_q == LAST_BIT) begin
                data_q      <= word_next;
                valid_q     <= 1'b1;
                bit_count_q <= '0;
              end else begin
                bit_count_q <= bit_count_q + BC_W'(1);
              end
            end
          end else if (counter_inc == MAX_C) begin
            // Stuck-high line: resync only after a full low gap.
            error_q     <= 1'b1;
            bit_count_q <= '0;
            counter_q   <= '0;
            state_q     <= WAIT_GAP;
          end else begin
            counter_q <= counter_inc;
          end
        end
        LOW: begin
          if (rise) begin
            counter_q <= '0;
            state_q   <= HIGH;
          end else if (counter_inc == RESET_C) begin
            frame_end_q <= 1'b1;
            counter_q   <= '0;
            state_q     <= IDLE;
            if (bit_count_q != '0) begin
              error_q     <= 1'b1;
              bit_count_q <= '0;
            end
          end else begin
            counter_q <= counter_inc;
          end
        end
        default: state_q <= WAIT_GAP;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_end = frame_end_q;
  assign error     = error_q;

endmodule

// File: tb/tb_unipolar_rz_receiver.sv
// Bench for unipolar_rz_receiver: a normal and an inverted instance see the same
// randomized pulse trains and are scored against a pulse-width reference model.
module tb_unipolar_rz_receiver;

  localparam int W   = 24;
  localparam int GAP = 2600;
  localparam int LAT = 4;  // line change until the FSM acts on it
  localparam int MIN_H = int'(50.0e6 * 0.15e-6);
  localparam int THR_H = int'(50.0e6 * 0.6e-6);
  localparam int MAX_H = int'(50.0e6 * 2.0e-6);
  localparam int RST_L = int'(50.0e6 * 50e-6);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic line  = 1'b0;
  logic line_n;
  logic [W-1:0] data0, data1;
  logic valid0, valid1, fe0, fe1, err0, err1;

  assign line_n = ~line;
  always #10 clock = ~clock;

  unipolar_rz_receiver #(.DATA_WIDTH(W), .INVERT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .line(line), .data(data0),
    .valid(valid0), .frame_end(fe0), .error(err0)
  );

  unipolar_rz_receiver #(.DATA_WIDTH(W), .INVERT(1'b1)) dut1 (
    .clock(clock), .reset(reset), .line(line_n), .data(data1),
    .valid(valid1), .frame_end(fe1), .error(err1)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Observation only; all judgements happen in the initial block.
  logic [1:0] m_valid, m_fe, m_err;
  assign m_valid = {valid1, valid0};
  assign m_fe    = {fe1, fe0};
  assign m_err   = {err1, err0};

  int obs_valid[2] = '{0, 0};
  int obs_fe[2]    = '{0, 0};
  int obs_err[2]   = '{0, 0};
  int obs_coinc[2] = '{0, 0};
  int obs_vfe[2]   = '{0, 0};
  int last_valid_cyc[2] = '{0, 0};
  int prev_valid_cyc[2] = '{0, 0};
  int last_fe_cyc[2]    = '{0, 0};
  int last_err_cyc[2]   = '{0, 0};
  logic [W-1:0] obs_words0[$];
  logic [W-1:0] obs_words1[$];

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i]) begin
        obs_valid[i]      <= obs_valid[i] + 1;
        prev_valid_cyc[i] <= last_valid_cyc[i];
        last_valid_cyc[i] <= cyc;
      end
      if (m_fe[i]) begin
        obs_fe[i]      <= obs_fe[i] + 1;
        last_fe_cyc[i] <= cyc;
      end
      if (m_err[i]) begin
        obs_err[i]      <= obs_err[i] + 1;
        last_err_cyc[i] <= cyc;
      end
      if (m_fe[i] && m_err[i]) obs_coinc[i] <= obs_coinc[i] + 1;
      if (m_valid[i] && m_fe[i]) obs_vfe[i] <= obs_vfe[i] + 1;
    end
    if (valid0) obs_words0.push_back(data0);
    if (valid1) obs_words1.push_back(data1);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model over whole line runs (level held for len cycles).
  // A pulse N line cycles wide is measured as N-1 counts by the receiver.
  int           m_state = 0;  // 0 resync, 1 idle, 2 after a bit
  int           m_nb    = 0;
  logic [W-1:0] m_acc   = '0;
  logic [W-1:0] exp_words[$];
  int           exp_fe = 0, exp_err = 0, exp_coinc = 0;
  int           w_checked = 0;
  logic         run_level = 1'b0;
  int           run_len   = 0;
  int           last_fall = 0, last_rise = 0;

  task automatic model_run(input logic lvl, input int len);
    if (lvl) begin
      if (m_state != 0) begin
        if ((len - 1 < MIN_H) || (len > MAX_H)) begin
          exp_err++;
          m_nb    = 0;
          m_state = 0;
        end else begin
          m_acc[m_nb] = (len - 1 > THR_H);
          m_nb++;
          if (m_nb == W) begin
            exp_words.push_back(m_acc);
            m_nb = 0;
          end
          m_state = 2;
        end
      end
    end else begin
      if (m_state == 0) begin
        if (len >= RST_L) m_state = 1;
      end else if (m_state == 2 && len > RST_L) begin
        exp_fe++;
        if (m_nb != 0) begin
          exp_err++;
          exp_coinc++;
          m_nb = 0;
        end
        m_state = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic lvl, input int len);
    if (lvl !== run_level) begin
      model_run(run_level, run_len);
      run_level = lvl;
      run_len   = 0;
      if (lvl) last_rise = cyc;
      else last_fall = cyc;
    end
    line = lvl;
    run_len += len;
    repeat (len) tick();
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int from, input int to, input bit fixed);
    for (int b = from; b < to; b++) begin
      int hi;
      int lo;
      if (fixed) begin
        hi = w[b] ? 40 : 20;
        lo = w[b] ? 22 : 42;
      end else begin
        hi = w[b] ? int'($urandom_range(90, 34)) : int'($urandom_range(28, 10));
        lo = int'($urandom_range(60, 20));
      end
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  task automatic apply_reset();
    line      = 1'b0;
    run_level = 1'b0;
    run_len   = 0;
    m_state   = 0;
    m_nb      = 0;
    reset     = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic check_phase(input string name);
    model_run(run_level, run_len);
    run_len = 0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s valid_count dut%0d", name, i), obs_valid[i], exp_words.size());
      check($sformatf("%s frame_end_count dut%0d", name, i), obs_fe[i], exp_fe);
      check($sformatf("%s error_count dut%0d", name, i), obs_err[i], exp_err);
      check($sformatf("%s fe_err_same_cycle dut%0d", name, i), obs_coinc[i], exp_coinc);
      check($sformatf("%s valid_with_frame_end dut%0d", name, i), obs_vfe[i], 0);
    end
    for (int k = w_checked; k < exp_words.size(); k++) begin
      if (k < obs_words0.size()) check($sformatf("%s word%0d dut0", name, k), obs_words0[k], exp_words[k]);
      if (k < obs_words1.size()) check($sformatf("%s word%0d dut1", name, k), obs_words1[k], exp_words[k]);
    end
    w_checked = exp_words.size();
  endtask

  initial begin
    int f1, f2, fall_a, rise_e;
    logic [W-1:0] w;

    repeat (5) tick();
    check("reset data dut0", data0, 0);
    check("reset data dut1", data1, 0);
    check("reset flags dut0", {valid0, fe0, err0}, 0);
    check("reset flags dut1", {valid1, fe1, err1}, 0);
    reset = 1'b0;

    // Known word with nominal pulse widths.
    drive(1'b0, GAP);
    send_bits(24'h00A5F0, 0, W, 1'b1);
    fall_a = last_fall;
    drive(1'b0, GAP);
    check_phase("A");
    check("A data dut0", data0, 24'h00A5F0);
    check("A data dut1", data1, 24'h00A5F0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("A valid_time dut%0d", i), last_valid_cyc[i], fall_a + LAT);
      check($sformatf("A frame_end_time dut%0d", i), last_fe_cyc[i], fall_a + LAT + RST_L);
    end

    // Back-to-back words with no gap.
    send_bits(24'h123456, 0, W, 1'b0);
    f1 = last_fall;
    send_bits(24'hFEDCBA, 0, W, 1'b0);
    f2 = last_fall;
    drive(1'b0, GAP);
    check_phase("B");
    for (int i = 0; i < 2; i++)
      check($sformatf("B valid_spacing dut%0d", i), last_valid_cyc[i] - prev_valid_cyc[i], f2 - f1);

    // Partial word closed by a gap, then a full word.
    send_bits(W'($urandom()), 0, 10, 1'b0);
    drive(1'b0, GAP);
    check_phase("C1");
    send_bits(W'($urandom()), 0, W, 1'b0);
    drive(1'b0, GAP);
    check_phase("C2");

    // Glitch mid-word; the rest of that word must be ignored.
    w = W'($urandom());
    send_bits(w, 0, 2, 1'b0);
    drive(1'b1, 5);
    drive(1'b0, 30);
    send_bits(w, 2, W, 1'b0);
    drive(1'b0, GAP);
    send_bits(W'($urandom()), 0, W, 1'b0);
    drive(1'b0, GAP);
    check_phase("D");

    // Stuck-high pulse.
    drive(1'b1, 150);
    rise_e = last_rise;
    for (int i = 0; i < 2; i++)
      check($sformatf("E max_high_error_time dut%0d", i), last_err_cyc[i], rise_e + LAT + MAX_H);
    drive(1'b0, GAP);
    send_bits(W'($urandom()), 0, W, 1'b0);
    drive(1'b0, GAP);
    check_phase("E");

    // Reset in the middle of a word.
    send_bits(W'($urandom()), 0, 12, 1'b0);
    apply_reset();
    drive(1'b0, GAP);
    send_bits(W'($urandom()), 0, W, 1'b0);
    drive(1'b0, GAP);
    check_phase("F");

    // Random continuous stream.
    for (int n = 0; n < 3; n++) send_bits(W'($urandom()), 0, W, 1'b0);
    drive(1'b0, GAP);
    check_phase("G");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
